// File: rtl/seq_det_pkg.sv
`default_nettype none
// ==========================================================================
// seq_det_pkg : shared constants, state encoding and length clamp
// Rev 1.0
// ==========================================================================
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // A zero length means a single-bit pattern; over-long lengths use the full register.
  function automatic int clamp_len(input int len, input int max_len);
    if (len <= 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ==========================================================================
// sat_counter : saturating up-counter, clear has priority over increment
// Rev 1.0
// ==========================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ==========================================================================
// seq_detector_param : runtime-programmable Mealy serial pattern detector
// Rev 1.0
// ==========================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               seq_det,
  output logic               seq_det_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_valid
);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_seq_det_q;

  logic [MAX_LEN-1:0] w_shift;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_seq_det;

  assign w_shift = {r_hist[MAX_LEN-2:0], din};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  // Enough history has been seen once fill reaches len-1; the current din completes it.
  assign w_fill_ok = (r_len == '0) || (r_fill >= (r_len - LEN_W'(1)));

  assign w_seq_det = (r_state == ST_RUN) && valid && !cfg_load && w_fill_ok &&
                     (((w_shift ^ r_pattern) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_UNCFG;
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_seq_det_q <= 1'b0;
    end else begin
      r_seq_det_q <= w_seq_det;
      case (r_state)
        ST_UNCFG: begin
          if (cfg_load) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!cfg_load && valid) begin
            if (w_seq_det && !r_overlap) begin
              r_hist <= '0;
              r_fill <= '0;
            end else begin
              r_hist <= w_shift;
              if (r_fill != LEN_W'(MAX_LEN)) r_fill <= r_fill + LEN_W'(1);
            end
          end
        end
        default: r_state <= ST_UNCFG;
      endcase
      if (cfg_load) begin
        r_state   <= ST_RUN;
        r_pattern <= pattern;
        r_len     <= LEN_W'(clamp_len(int'(pat_len), MAX_LEN));
        r_overlap <= overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_seq_det),
    .clr (cnt_clr),
    .q   (match_count)
  );

  assign seq_det   = w_seq_det;
  assign seq_det_q = r_seq_det_q;
  assign cfg_valid = (r_state == ST_RUN);

endmodule
`default_nettype wire
